// File: rtl/burst_mem_if.sv
// Request/response bundle between a memory master (fetch or data stage) and burst_mem.
// The master drives the request side; the memory returns data, busy, valid and err.
interface burst_mem_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  logic                    en;
  logic                    wren;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [1:0]              acc_size;
  logic [DATA_SIZE-1:0]    d_in;
  logic [DATA_SIZE-1:0]    d_out;
  logic                    busy;
  logic                    valid;
  logic                    err;

  modport master (
    output en, wren, addr, acc_size, d_in,
    input  d_out, busy, valid, err
  );

  modport slave (
    input  en, wren, addr, acc_size, d_in,
    output d_out, busy, valid, err
  );
endinterface

// File: rtl/burst_mem.sv
// Big-endian byte-addressed main memory with wait states, sub-word access and word bursts.
// One transaction at a time; malformed or out-of-range requests get a one-cycle err pulse.
//
//   state  | meaning
//   S_IDLE | waiting for en; request checked and captured here
//   S_WAIT | wait-state countdown, LATENCY cycles
//   S_XFER | one beat per cycle; reads drive d_out, writes commit at the closing edge
//   S_ERR  | rejected request, err pulses for this single cycle
module burst_mem #(
  parameter int                      ADDRESS_SIZE  = 32,
  parameter int                      DATA_SIZE     = 32,
  parameter int                      MEM_SIZE      = 1048576,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000,
  parameter int                      LATENCY       = 2,
  parameter int                      BURST_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  burst_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;
  localparam int AW1   = ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wren_q, wren_d;
  logic [1:0]           size_q, size_d;
  logic [DATA_SIZE-1:0] wdat_q, wdat_d;
  logic [DATA_SIZE-1:0] d_out_q, d_out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [DATA_SIZE-1:0] mem [WORDS];

  logic [ADDRESS_SIZE-1:0] req_off;
  logic [AW1-1:0]          req_nbytes;
  logic [AW1-1:0]          req_end;
  logic                    req_bad;

  always_comb begin
    req_off = bus.addr - START_ADDRESS;
    case (bus.acc_size)
      2'b00:   req_nbytes = AW1'(1);
      2'b01:   req_nbytes = AW1'(2);
      2'b10:   req_nbytes = AW1'(4);
      default: req_nbytes = AW1'(4 * BURST_LEN);
    endcase
    req_end = {1'b0, req_off} + req_nbytes;
    req_bad = (bus.addr < START_ADDRESS) || (req_end > AW1'(MEM_SIZE)) ||
              ((bus.acc_size == 2'b01) && bus.addr[0]) ||
              (bus.acc_size[1] && (bus.addr[1:0] != 2'b00));
  end

  // Read data for the beat about to be presented: first beat from idx_q, later beats one word on.
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_SIZE-1:0] rd_word;
  logic [DATA_SIZE-1:0] rd_data;

  always_comb begin
    rd_idx  = (state_q == S_XFER) ? idx_q + IDX_W'(4) : idx_q;
    rd_word = mem[rd_idx[IDX_W-1:2]];
    rd_data = rd_word;
    case (size_q)
      2'b00: begin
        case (rd_idx[1:0])
          2'd0:    rd_data = {24'h0, rd_word[31:24]};
          2'd1:    rd_data = {24'h0, rd_word[23:16]};
          2'd2:    rd_data = {24'h0, rd_word[15:8]};
          default: rd_data = {24'h0, rd_word[7:0]};
        endcase
      end
      2'b01:   rd_data = rd_idx[1] ? {16'h0, rd_word[15:0]} : {16'h0, rd_word[31:16]};
      default: rd_data = rd_word;
    endcase
  end

  logic                 mem_we;
  logic [3:0]           wr_be;
  logic [DATA_SIZE-1:0] wr_word;

  always_comb begin
    case (size_q)
      2'b00: begin
        wr_be   = 4'b1000 >> idx_q[1:0];
        wr_word = {4{wdat_q[7:0]}};
      end
      2'b01: begin
        wr_be   = idx_q[1] ? 4'b0011 : 4'b1100;
        wr_word = {2{wdat_q[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_word = wdat_q;
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = bus.d_in;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wren_d  = wren_q;
    size_d  = size_q;
    wdat_d  = wdat_q;
    d_out_d = d_out_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          idx_d   = req_off[IDX_W-1:0];
          wren_d  = bus.wren;
          size_d  = bus.acc_size;
          wdat_d  = bus.d_in;
          cnt_d   = 4'(LATENCY - 1);
          state_d = req_bad ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_XFER;
          cnt_d   = (size_q == 2'b11) ? 4'(BURST_LEN - 1) : 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_XFER: begin
        mem_we = wren_q;
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          idx_d = idx_q + IDX_W'(4);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_WAIT) || (state_d == S_XFER);
    err_d   = (state_d == S_ERR);
    valid_d = (state_d == S_XFER) && !wren_q;
    if (valid_d) d_out_d = rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wren_q  <= 1'b0;
      size_q  <= 2'b00;
      wdat_q  <= '0;
      d_out_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wren_q  <= wren_d;
      size_q  <= size_d;
      wdat_q  <= wdat_d;
      d_out_q <= d_out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx_q[IDX_W-1:2]][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_burst_mem.sv
// Scoreboarded bench for burst_mem: a byte-array reference model predicts read beats,
// a negedge monitor compares every valid beat, the driver checks busy/valid/err per cycle.
module tb_burst_mem;
  localparam int          AS       = 32;
  localparam int          DS       = 32;
  localparam int          MEM_SIZE = 1048576;
  localparam int          LAT      = 2;
  localparam int          BL       = 4;
  localparam logic [31:0] START    = 32'h80020000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  burst_mem_if #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS)) bus ();

  burst_mem #(
    .ADDRESS_SIZE(AS), .DATA_SIZE(DS), .MEM_SIZE(MEM_SIZE),
    .START_ADDRESS(START), .LATENCY(LAT), .BURST_LEN(BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  model [int];
  logic [31:0] exp_q [$];
  logic [31:0] bw [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mb(input int i);
    return model.exists(i) ? model[i] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz);
    int i = int'(a - START);
    case (sz)
      2'd0:    return {24'h0, mb(i)};
      2'd1:    return {16'h0, mb(i), mb(i + 1)};
      default: return {mb(i), mb(i + 1), mb(i + 2), mb(i + 3)};
    endcase
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int i = int'(a - START);
    case (sz)
      2'd0: model[i] = d[7:0];
      2'd1: begin model[i] = d[15:8]; model[i + 1] = d[7:0]; end
      default: begin
        model[i] = d[31:24]; model[i + 1] = d[23:16];
        model[i + 2] = d[15:8]; model[i + 3] = d[7:0];
      end
    endcase
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
    longint nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 4 * BL;
    if (a < START) return 1'b1;
    if (longint'(a - START) + nb > longint'(MEM_SIZE)) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz[1] && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: d_out %h with no read beat outstanding at %0t", bus.d_out, $time);
      end else begin
        check("rd_data", bus.d_out, exp_q.pop_front());
      end
    end
  end

  // Called at (or just after) a negedge; returns at the negedge of the first idle cycle.
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input int abort_k, input bit hold_en);
    int guard = 0;
    int n;
    bit bad;
    while ((bus.busy || bus.err) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy %b err %b, expected idle within 100 cycles", bus.busy, bus.err);
      return;
    end
    bad = ref_bad(a, sz);
    n   = (sz == 2'd3) ? BL : 1;
    bus.en = 1'b1; bus.wren = wr; bus.addr = a; bus.acc_size = sz; bus.d_in = d;
    if (!bad) begin
      if (!wr) begin
        for (int j = 0; j < n; j++)
          exp_q.push_back(ref_read(a + 32'(4 * j), (sz == 2'd3) ? 2'd2 : sz));
      end else if (sz != 2'd3) begin
        ref_write(a, sz, d);
      end
    end
    @(posedge clk);
    #1;
    if (!hold_en) bus.en = 1'b0;
    bus.addr = $urandom; bus.wren = 1'($urandom); bus.acc_size = 2'($urandom); bus.d_in = $urandom;
    if (bad) begin
      @(negedge clk);
      check("rej_err_c1", 32'(bus.err), 32'd1);
      check("rej_busy_c1", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("rej_err_c2", 32'(bus.err), 32'd0);
      check("rej_busy_c2", 32'(bus.busy), 32'd0);
      return;
    end
    for (int k = 1; k <= LAT + n + 1; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_dout", bus.d_out, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        return;
      end
      if (wr && sz == 2'd3 && k > LAT && k <= LAT + n) begin
        bus.d_in = bw[k - LAT - 1];
        ref_write(a + 32'(4 * (k - LAT - 1)), 2'd2, bw[k - LAT - 1]);
      end
      @(negedge clk);
      check("busy_cycle", 32'(bus.busy), 32'(k <= LAT + n));
      check("valid_cycle", 32'(bus.valid), 32'(!wr && k > LAT && k <= LAT + n));
      check("err_cycle", 32'(bus.err), 32'd0);
      if (k < LAT + n + 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bit          wr;
    int          r;
    bus.en = 1'b0; bus.wren = 1'b0; bus.addr = '0; bus.acc_size = 2'b00; bus.d_in = '0;
    #23;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_dout", bus.d_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 32'h80020010, 2'd2, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 32'h80020010, 2'd2, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'h80020013, 2'd0, 32'h123456A5, 0, 1'b0);
    do_txn(1'b0, 32'h80020010, 2'd2, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h80020012, 2'd1, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h80020010, 2'd0, 32'h0, 0, 1'b0);

    for (int j = 0; j < BL; j++) bw[j] = 32'h11111111 * 32'(j + 1);
    do_txn(1'b1, 32'h80020100, 2'd3, 32'h0, 0, 1'b0);
    do_txn(1'b0, 32'h80020100, 2'd3, 32'h0, 0, 1'b0);

    do_txn(1'b0, 32'h8001FFFC, 2'd2, 32'h0, 0, 1'b0);
    do_txn(1'b1, 32'h80020001, 2'd1, 32'hFFFF, 0, 1'b0);
    do_txn(1'b0, 32'h80020000, 2'd2, 32'h0, 0, 1'b0);
    for (int j = 0; j < BL; j++) bw[j] = $urandom;
    do_txn(1'b1, START + 32'(MEM_SIZE) - 32'd8, 2'd3, 32'h0, 0, 1'b0);
    do_txn(1'b0, START + 32'(MEM_SIZE) - 32'd8, 2'd2, 32'h0, 0, 1'b0);
    do_txn(1'b1, START + 32'(MEM_SIZE) - 32'd4, 2'd2, 32'hCAFEF00D, 0, 1'b0);
    do_txn(1'b0, START + 32'(MEM_SIZE) - 32'd4, 2'd2, 32'h0, 0, 1'b0);

    do_txn(1'b0, 32'h80020100, 2'd3, 32'h0, LAT + 2, 1'b0);
    do_txn(1'b0, 32'h80020104, 2'd2, 32'h0, 0, 1'b0);

    do_txn(1'b0, 32'h80020010, 2'd2, 32'h0, 0, 1'b1);
    do_txn(1'b0, 32'h80020100, 2'd2, 32'h0, 0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      wr = 1'($urandom);
      sz = 2'($urandom);
      r  = $urandom_range(0, 9);
      if (r == 0)      a = START - 32'(4 * $urandom_range(1, 4));
      else if (r == 1) a = START + 32'(MEM_SIZE) - 32'(4 * $urandom_range(0, 20));
      else             a = START + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz[1])      a[1:0] = 2'b00;
      end
      for (int j = 0; j < BL; j++) bw[j] = $urandom;
      do_txn(wr, a, sz, $urandom, 0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
